compressor_stream: RTL and testbench
====================================

COMPRESSOR_STREAM -- requirements
Module: compressor_stream

Interface
REQ-001 SHALL have parameter OUT_W, default 16, total output width in bits (sign + OUT_W-1 magnitude bits); legal range 8..24.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_data holds a valid float32 sample.
REQ-005 SHALL have port in_ready  output  1  block accepts the sample this cycle.
REQ-006 SHALL have port in_data  input  32  IEEE-754 single-precision sample.
REQ-007 SHALL have port out_valid  output  1  out_data/out_sat hold a valid result.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-009 SHALL have port out_data  output  OUT_W  sign-magnitude fixed point, FRAC_W = OUT_W-1 fractional bits, range (-1,1).
REQ-010 SHALL have port out_sat  output  1  the result in out_data was saturated.
REQ-011 SHALL have port sat_count  output  16  number of saturated results delivered since reset.

Function
REQ-012 Transfer SHALL occur on in_valid&&in_ready (input) and on out_valid&&out_ready (output).
REQ-013 Pipeline SHALL be 2 register stages (S1 decode: sign, shift = 127-exp, class flags; S2: shifted and rounded result), with latency exactly 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-014 Advance enable SHALL be en = !out_valid | out_ready; in_ready = en; both stages load only when en; no bubble collapsing is required.
REQ-015 While out_valid && !out_ready, out_data, out_sat and out_valid SHALL hold stable.
REQ-016 Sustained throughput SHALL be 1 sample/cycle with out_ready high.
REQ-017 Magnitude for 1 <= exp <= 126 SHALL be floor({1,mantissa} * 2^(exp-127+FRAC_W-23)), i.e. the 24-bit hidden mantissa shifted right by (127-exp) with bits [22:23-FRAC_W] kept.
REQ-018 When the shift is >= 24, the magnitude SHALL be 0 (no wrap of the shift amount).
REQ-019 exp == 0 (zero/denormal) SHALL give magnitude 0 with out_sat = 0.
REQ-020 exp >= 127 (|x| >= 1.0, Inf, NaN) SHALL give magnitude 2^FRAC_W-1 with out_sat = 1.
REQ-021 The out_data MSB SHALL equal the input sign bit in all cases, including -0 and NaN.
REQ-022 sat_count SHALL increment by 1 on each output transfer with out_sat = 1, and SHALL stick at 0xFFFF.

Reset
REQ-023 rst high SHALL immediately clear S1/S2 valid bits, out_valid, out_data, out_sat and sat_count to 0, regardless of clk.
REQ-024 Samples in flight at reset SHALL be discarded; in_ready SHALL read 1 during and after reset.

Configuration
REQ-025 Macro COMPRESSOR_ROUND_EN defined: the magnitude SHALL round to nearest, half up (add the first discarded bit); a carry to 2^FRAC_W SHALL saturate to 2^FRAC_W-1 with out_sat = 1.
REQ-026 COMPRESSOR_ROUND_EN undefined: the magnitude SHALL truncate per REQ-017, with no rounding logic present; latency is 2 cycles in both builds.

Verification (OUT_W=16)
REQ-027 Input 0x3F000000 (0.5) -> 0x4000, sat 0; input 0xBE800000 (-0.25) -> 0xA000, sat 0; each 2 cycles after acceptance.
REQ-028 Input 0x3F800000 (1.0) then 0xFF800000 (-Inf) -> 0x7FFF then 0xFFFF, both sat 1; sat_count = 2.
REQ-029 Input 0x00000000 -> 0x0000; 0x80000001 -> 0x8000; 0x35800000 (2^-20) -> 0x0000; all sat 0.
REQ-030 Input 0x37800000 (2^-16) -> 0x0000 without macro, 0x0001 with COMPRESSOR_ROUND_EN; 0x3F7FFFFF -> 0x7FFF, sat 0 without macro, sat 1 with it.
REQ-031 Stream 8 samples back-to-back while out_ready toggles 1,0,0,1,... -> all 8 results delivered in order, none lost or duplicated, out_data stable during stalls, in_ready = 0 exactly when out_valid && !out_ready.
REQ-032 Assert rst while 2 samples are in flight -> out_valid drops immediately, sat_count = 0, and no stale result appears after release.

Source files
------------

// File: rtl/compressor_stream.sv
// Float32 to sign-magnitude fixed-point compressor with a 2-stage valid/ready pipeline.
// Optional round-to-nearest (half up) is enabled by defining COMPRESSOR_ROUND_EN.
module compressor_stream #(
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_sat,
   output logic [15:0]      sat_count
);

   localparam int FRAC_W = OUT_W - 1;
   localparam int DROP   = 23 - FRAC_W;

   logic en;

   logic        s1_valid_q, s1_valid_d;
   logic        s1_sign_q, s1_sign_d;
   logic        s1_zero_q, s1_zero_d;
   logic        s1_sat_q, s1_sat_d;
   logic [7:0]  s1_shift_q, s1_shift_d;
   logic [22:0] s1_mant_q, s1_mant_d;

   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic             out_sat_q, out_sat_d;
   logic [15:0]      sat_count_q, sat_count_d;

   logic [FRAC_W-1:0] mag;
   logic              mag_sat;
   logic [5:0]        shamt;
`ifdef COMPRESSOR_ROUND_EN
   logic [FRAC_W:0]   window;
   logic [FRAC_W:0]   rounded;
`endif

   assign en        = !out_valid_q || out_ready;
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;
   assign sat_count = sat_count_q;

   // Stage-2 magnitude: one right shift folds in both 127-exp and the dropped low mantissa bits.
   always_comb begin
      shamt   = {1'b0, s1_shift_q[4:0]} + 6'(DROP);
      mag     = '0;
      mag_sat = 1'b0;
`ifdef COMPRESSOR_ROUND_EN
      window  = '0;
      rounded = '0;
`endif
      if (s1_sat_q) begin
         mag     = '1;
         mag_sat = 1'b1;
      end else if (!s1_zero_q && (s1_shift_q < 8'd24)) begin
`ifdef COMPRESSOR_ROUND_EN
         window  = (FRAC_W+1)'({1'b1, s1_mant_q, 1'b0} >> shamt);
         rounded = {1'b0, window[FRAC_W:1]} + (FRAC_W+1)'(window[0]);
         if (rounded[FRAC_W]) begin
            mag     = '1;
            mag_sat = 1'b1;
         end else begin
            mag = rounded[FRAC_W-1:0];
         end
`else
         mag = FRAC_W'({1'b1, s1_mant_q} >> shamt);
`endif
      end
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_sign_d   = s1_sign_q;
      s1_zero_d   = s1_zero_q;
      s1_sat_d    = s1_sat_q;
      s1_shift_d  = s1_shift_q;
      s1_mant_d   = s1_mant_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      sat_count_d = sat_count_q;

      if (en) begin
         s1_valid_d  = in_valid;
         s1_sign_d   = in_data[31];
         s1_zero_d   = (in_data[30:23] == 8'd0);
         s1_sat_d    = (in_data[30:23] >= 8'd127);
         s1_shift_d  = 8'd127 - in_data[30:23];
         s1_mant_d   = in_data[22:0];
         out_valid_d = s1_valid_q;
         out_data_d  = {s1_sign_q, mag};
         out_sat_d   = mag_sat;
      end

      // Count saturated results as they leave, sticking at all-ones.
      if (out_valid_q && out_ready && out_sat_q && (sat_count_q != 16'hFFFF)) begin
         sat_count_d = sat_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_sat_q    <= 1'b0;
         s1_shift_q  <= '0;
         s1_mant_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         sat_count_q <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_zero_q   <= s1_zero_d;
         s1_sat_q    <= s1_sat_d;
         s1_shift_q  <= s1_shift_d;
         s1_mant_q   <= s1_mant_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         sat_count_q <= sat_count_d;
      end
   end

endmodule

// File: tb/tb_compressor_stream.sv
// Directed self-checking bench for compressor_stream at OUT_W=16.
// Rounding expectations follow COMPRESSOR_ROUND_EN when the bench is built with it.
module tb_compressor_stream;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_sat;
   logic [15:0] sat_count;

   int errors = 0;
   int checks = 0;

   compressor_stream #(.OUT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   task automatic do_reset;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Sends one sample with out_ready high; returns the result and edges until out_valid.
   task automatic xfer(input logic [31:0] d, output logic [15:0] od, output logic os,
                       output int lat);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      od = out_data;
      os = out_sat;
   endtask

   task automatic test_reset;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid);
      end
      checks++;
      if (out_data !== 16'h0000) begin
         errors++; $display("[TB] FAIL reset_out_data got=%h want=0000", out_data);
      end
      checks++;
      if (out_sat !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_out_sat got=%b want=0", out_sat);
      end
      checks++;
      if (sat_count !== 16'h0000) begin
         errors++; $display("[TB] FAIL reset_sat_count got=%h want=0000", sat_count);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [31:0] stim [3];
      logic [15:0] want [3];
      logic [15:0] od;
      logic        os;
      int          lat;
      stim[0] = 32'h3F000000; want[0] = 16'h4000;
      stim[1] = 32'hBE800000; want[1] = 16'hA000;
      stim[2] = 32'h3F400000; want[2] = 16'h6000;
      do_reset;
      for (int i = 0; i < 3; i++) begin
         xfer(stim[i], od, os, lat);
         checks++;
         if (lat !== 2) begin
            errors++; $display("[TB] FAIL basic_latency[%0d] got=%0d want=2", i, lat);
         end
         checks++;
         if (od !== want[i] || os !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_data[%0d] got=%h/%b want=%h/0", i, od, os, want[i]);
         end
      end
   endtask

   task automatic test_saturation;
      logic [31:0] stim [4];
      logic [15:0] want [4];
      logic [15:0] od;
      logic        os;
      int          lat;
      stim[0] = 32'h3F800000; want[0] = 16'h7FFF;
      stim[1] = 32'hFF800000; want[1] = 16'hFFFF;
      stim[2] = 32'h7FC00000; want[2] = 16'h7FFF;
      stim[3] = 32'hFFC00000; want[3] = 16'hFFFF;
      do_reset;
      for (int i = 0; i < 4; i++) begin
         xfer(stim[i], od, os, lat);
         checks++;
         if (od !== want[i] || os !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_data[%0d] got=%h/%b want=%h/1", i, od, os, want[i]);
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (sat_count !== 16'd4) begin
         errors++; $display("[TB] FAIL sat_count got=%0d want=4", sat_count);
      end
   endtask

   task automatic test_zero;
      logic [31:0] stim [4];
      logic [15:0] want [4];
      logic [15:0] od;
      logic        os;
      int          lat;
      stim[0] = 32'h00000000; want[0] = 16'h0000;
      stim[1] = 32'h80000001; want[1] = 16'h8000;
      stim[2] = 32'h35800000; want[2] = 16'h0000;
      stim[3] = 32'hB3800000; want[3] = 16'h8000;
      do_reset;
      for (int i = 0; i < 4; i++) begin
         xfer(stim[i], od, os, lat);
         checks++;
         if (od !== want[i] || os !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_data[%0d] got=%h/%b want=%h/0", i, od, os, want[i]);
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (sat_count !== 16'd0) begin
         errors++; $display("[TB] FAIL zero_sat_count got=%0d want=0", sat_count);
      end
   endtask

   task automatic test_rounding;
      logic [15:0] od;
      logic        os;
      int          lat;
      logic [15:0] want_small;
      logic        want_sat;
`ifdef COMPRESSOR_ROUND_EN
      want_small = 16'h0001;
      want_sat   = 1'b1;
`else
      want_small = 16'h0000;
      want_sat   = 1'b0;
`endif
      do_reset;
      xfer(32'h37800000, od, os, lat);
      checks++;
      if (od !== want_small || os !== 1'b0) begin
         errors++; $display("[TB] FAIL round_half got=%h/%b want=%h/0", od, os, want_small);
      end
      xfer(32'h3F7FFFFF, od, os, lat);
      checks++;
      if (od !== 16'h7FFF || os !== want_sat) begin
         errors++; $display("[TB] FAIL round_carry got=%h/%b want=7fff/%b", od, os, want_sat);
      end
      checks++;
      if (lat !== 2) begin
         errors++; $display("[TB] FAIL round_latency got=%0d want=2", lat);
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] stim [8];
      logic [15:0] want [8];
      logic [15:0] held;
      logic        stalled;
      int          sent;
      int          got;
      stim[0] = 32'h3F000000; want[0] = 16'h4000;
      stim[1] = 32'hBE800000; want[1] = 16'hA000;
      stim[2] = 32'h3F400000; want[2] = 16'h6000;
      stim[3] = 32'hBF800000; want[3] = 16'hFFFF;
      stim[4] = 32'h3E000000; want[4] = 16'h1000;
      stim[5] = 32'h00000000; want[5] = 16'h0000;
      stim[6] = 32'hBF000000; want[6] = 16'hC000;
      stim[7] = 32'h3EC00000; want[7] = 16'h3000;
      do_reset;
      sent    = 0;
      got     = 0;
      stalled = 1'b0;
      held    = '0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         out_ready = (cyc % 3 == 0);
         in_valid  = (sent < 8);
         in_data   = (sent < 8) ? stim[sent] : 32'h0;
         #1;
         checks++;
         if (in_ready !== !(out_valid && !out_ready)) begin
            errors++;
            $display("[TB] FAIL b2b_in_ready cyc=%0d got=%b want=%b", cyc, in_ready,
                     !(out_valid && !out_ready));
         end
         if (stalled) begin
            checks++;
            if (out_data !== held || out_valid !== 1'b1) begin
               errors++;
               $display("[TB] FAIL b2b_stall cyc=%0d got=%h/%b want=%h/1", cyc, out_data,
                        out_valid, held);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (out_data !== want[got]) begin
               errors++;
               $display("[TB] FAIL b2b_data[%0d] got=%h want=%h", got, out_data, want[got]);
            end
            got++;
         end
         stalled = out_valid && !out_ready;
         held    = out_data;
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got !== 8) begin
         errors++; $display("[TB] FAIL b2b_count got=%0d want=8", got);
      end
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL b2b_extra got=%b want=0", out_valid);
      end
   endtask

   task automatic test_reset_in_flight;
      do_reset;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'h3F800000;
      @(posedge clk);
      #1;
      in_data = 32'hFF800000;
      @(posedge clk);
      #1;
      in_data = 32'h7F800000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (sat_count !== 16'd1 || out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flight_pre got=%0d/%b want=1/1", sat_count, out_valid);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || sat_count !== 16'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flight_reset got=%b/%0d/%b want=0/0/1", out_valid, sat_count,
                  in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL flight_stale[%0d] got=%b want=0", i, out_valid);
         end
      end
   endtask

   initial begin
      clk       = 1'b0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      test_reset;
      test_basic;
      test_saturation;
      test_zero;
      test_rounding;
      test_back_to_back;
      test_reset_in_flight;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
